// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// master: fetch/decode side driving pushes and stall/flush; slave: the queue.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
) ();
    logic [31:0]             in_address;
    logic [31:0]             in_instruction;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic                    stall;
    logic [31:0]             out_address;
    logic [31:0]             out_instruction;
    logic                    out_valid;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output in_address, in_instruction, in_valid, flush, stall,
        input  in_ready, out_address, out_instruction, out_valid, count
    );

    modport slave (
        input  in_address, in_instruction, in_valid, flush, stall,
        output in_ready, out_address, out_instruction, out_valid, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: circular buffer of {address, instruction} pairs,
// first-word-fall-through toward decode, flushed on branch redirect.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      addr_mem  [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hold_addr_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Handshake decode and pointer/occupancy next state; flush discards everything.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        // Ready comes from the registered count only, so a full queue refuses
        // a push even if decode pops in the same cycle.
        push     = bus.in_valid & ~full & ~bus.flush;
        pop      = ~empty & ~bus.stall & ~bus.flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset needed since count gates visibility.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            addr_mem[wr_ptr_q]  <= bus.in_address;
            instr_mem[wr_ptr_q] <= bus.in_instruction;
        end
    end

    // Remember the last presented head address so it stays put once empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_addr_q <= '0;
        end else if (!empty) begin
            hold_addr_q <= addr_mem[rd_ptr_q];
        end
    end

    // Zero-latency head presentation toward decode.
    always_comb begin
        bus.in_ready        = ~full;
        bus.out_valid       = ~empty;
        bus.count           = count_q;
        bus.out_address     = empty ? hold_addr_q : addr_mem[rd_ptr_q];
        bus.out_instruction = empty ? NOP_INSTR : instr_mem[rd_ptr_q];
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries are queued on accepted
// pushes and compared/popped as the head is consumed by decode.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    logic clock;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    entry_t      sb[$];
    logic [31:0] last_addr;
    logic [31:0] next_addr;
    logic        accepted;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return {a[23:0], 8'h13} ^ 32'h5a00_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every visible output against the scoreboard model.
    task automatic check_outputs();
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        exp_addr  = (sb.size() != 0) ? sb[0].addr : last_addr;
        exp_instr = (sb.size() != 0) ? sb[0].instr : NOP;
        check("count", 64'(bus.count), 64'(sb.size()));
        check("in_ready", 64'(bus.in_ready), 64'(sb.size() < DEPTH));
        check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        check("out_address", 64'(bus.out_address), 64'(exp_addr));
        check("out_instruction", 64'(bus.out_instruction), 64'(exp_instr));
    endtask

    // One clock: drive at negedge, check, advance model, wait to next negedge.
    task automatic step(input logic v, input logic [31:0] a, input logic fl, input logic st);
        logic push_m;
        logic pop_m;
        bus.in_valid       = v;
        bus.in_address     = a;
        bus.in_instruction = mk_instr(a);
        bus.flush          = fl;
        bus.stall          = st;
        #1;
        check_outputs();
        push_m = v && (sb.size() < DEPTH) && !fl;
        pop_m  = (sb.size() != 0) && !st && !fl;
        if (sb.size() != 0) last_addr = sb[0].addr;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop_m) void'(sb.pop_front());
            if (push_m) sb.push_back('{addr: a, instr: mk_instr(a)});
        end
        accepted = push_m;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset(input logic v);
        reset              = 1'b1;
        bus.in_valid       = v;
        bus.in_address     = 32'h0000_0fc0;
        bus.in_instruction = mk_instr(32'h0000_0fc0);
        bus.flush          = 1'b0;
        bus.stall          = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        last_addr = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_addr = '0;
        next_addr = '0;
        accepted  = 1'b0;
        reset     = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_address = '0;
        bus.in_instruction = '0;
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        @(negedge clock);

        // Reset state
        do_reset(1'b0);
        #1;
        check_outputs();
        check("reset_instr", 64'(bus.out_instruction), 64'(NOP));

        // 1: three pushes, no stall, then drain
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("t1_count_zero", 64'(bus.count), 64'd0);

        // 2: stall, push four, fifth dropped, release stall
        next_addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, next_addr, 1'b0, 1'b1);
            if (accepted) next_addr += 4;
        end
        check("t2_full_count", 64'(bus.count), 64'(DEPTH));
        check("t2_full_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);

        // 3: full queue with push+pop, then push accepted
        for (int i = 0; i < 4; i++) begin
            step(1'b1, next_addr, 1'b0, 1'b1);
            if (accepted) next_addr += 4;
        end
        step(1'b1, next_addr, 1'b0, 1'b0);
        check("t3_rejected_count", 64'(bus.count), 64'd3);
        if (accepted) next_addr += 4;
        step(1'b1, next_addr, 1'b0, 1'b1);
        check("t3_accepted_count", 64'(bus.count), 64'd4);
        if (accepted) next_addr += 4;
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);

        // 4: two entries queued, flush with a push of 0x40
        step(1'b1, 32'h200, 1'b0, 1'b1);
        step(1'b1, 32'h204, 1'b0, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b0);
        check("t4_flush_instr", 64'(bus.out_instruction), 64'(NOP));
        check("t4_flush_valid", 64'(bus.out_valid), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);

        // 5: ten streaming push/pop cycles, pointers wrap
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b0);

        // Randomised mix of pushes, stalls and flushes
        next_addr = 32'h1000;
        for (int i = 0; i < 200; i++) begin
            logic v, st, fl;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 15) == 0);
            step(v, next_addr, fl, st);
            if (fl) next_addr = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
            else if (accepted) next_addr += 4;
        end
        step(1'b1, 32'h3000, 1'b1, 1'b0);

        // 6: reset with three entries and a push pending
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b1);
        check("t6_pre_count", 64'(bus.count), 64'd3);
        do_reset(1'b1);
        #1;
        check_outputs();
        check("t6_count", 64'(bus.count), 64'd0);
        check("t6_ready", 64'(bus.in_ready), 64'd1);
        check("t6_valid", 64'(bus.out_valid), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
